// File: rtl/core_dg_pkg.sv
// Shared types and constants for the 11-bit DG codeword decoder.
package core_dg_pkg;
  localparam int CW_W  = 11;
  localparam int DW    = 8;
  localparam int SYN_W = 3;

  // Parity bit positions inside the codeword.
  localparam int P0_IDX = 4;
  localparam int P1_IDX = 5;
  localparam int P2_IDX = 7;

  typedef logic [CW_W-1:0]  cw_t;
  typedef logic [SYN_W-1:0] syn_t;
  typedef logic [DW-1:0]    dbyte_t;

  // Flip codeword bit syn+3 when the syndrome is non-zero. The index is
  // widened to 4 bits so that syn+3 (up to 10) does not wrap.
  function automatic cw_t dg_correct(input cw_t cw, input syn_t syn);
    logic [3:0] idx;
    idx = {1'b0, syn} + 4'd3;
    if (syn == '0) return cw;
    return cw ^ (cw_t'(1) << idx);
  endfunction

  // Pick the eight data bits out of a (corrected) codeword.
  function automatic dbyte_t dg_extract(input cw_t cw);
    return {cw[10], cw[9], cw[8], cw[6], cw[3:0]};
  endfunction
endpackage

// File: rtl/core_dg_syndrome.sv
// Combinational syndrome generator; also usable by an encoder-side checker.
module core_dg_syndrome
  import core_dg_pkg::*;
(
  input  cw_t  cw,
  output syn_t syn
);
  // Each syndrome bit re-checks one parity group.
  always_comb begin
    syn    = '0;
    syn[0] = cw[P0_IDX] ^ cw[6] ^ cw[8] ^ cw[10];
    syn[1] = cw[P1_IDX] ^ cw[6] ^ cw[9] ^ cw[10];
    syn[2] = cw[P2_IDX] ^ cw[8] ^ cw[9] ^ cw[10];
  end
endmodule

// File: rtl/core_dg_dec.sv
// Two-stage DG decoder: S1 holds codeword + syndrome, S2 holds the
// corrected byte. Bits [3:0] are carried through without protection.
//
// Handshake: a word moves across an interface on every rising edge where
// valid and ready are both 1. A producer holding valid keeps its payload
// stable until ready is seen; ready never depends on valid on the same side.
module core_dg_dec
  import core_dg_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  cw_t              in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output dbyte_t           out_data,
  output logic             out_corr,
  output syn_t             out_syn,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  logic s1_valid;
  cw_t  s1_cw;
  syn_t s1_syn;
  logic s2_valid;
  syn_t in_syn;
  logic s1_load;
  logic s2_load;

  core_dg_syndrome u_syn (
    .cw  (in_data),
    .syn (in_syn)
  );

  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = !s1_valid || !s2_valid || out_ready;
  assign out_valid = s2_valid;

  // Pipeline advance: each stage loads when it is empty or drains downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
      s1_syn   <= '0;
      s2_valid <= 1'b0;
      out_data <= '0;
      out_corr <= 1'b0;
      out_syn  <= '0;
    end else begin
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= dg_extract(dg_correct(s1_cw, s1_syn));
          out_corr <= (s1_syn != '0);
          out_syn  <= s1_syn;
        end
      end
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_cw  <= in_data;
          s1_syn <= in_syn;
        end
      end
    end
  end

  // Saturating count of corrected words leaving the block; clear has priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= '0;
    end else if (s2_valid && out_ready && out_corr && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end
endmodule
